pipeline_scoreboard: RTL and testbench

Tracks destination-register metadata of in-flight instructions through the EXE, MEM and WB stages of the 5-stage core. It is the producer of the `Exe_Dest`/`Exe_WB_EN`/`Exe_Mem_R_EN`/`Mem_Dest`/`Mem_WB_EN` signals that the hazard detection logic consumes, and it replaces the scattered per-stage copies of those fields. It honours memory freeze, branch flush and hazard bubble insertion, and publishes a per-register pending mask.

---
 rtl/pipeline_scoreboard_if.sv | 35 +++
 rtl/pipeline_scoreboard.sv | 76 +++++++
 tb/tb_pipeline_scoreboard.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_scoreboard_if.sv
// Bundle of the ID-side inputs, the stall/flush controls and the per-stage slot
// outputs of the pipeline scoreboard.
interface pipeline_scoreboard_if;
  logic        freeze;
  logic        flush;
  logic        hazard;
  logic [3:0]  ID_Dest;
  logic        ID_WB_EN;
  logic        ID_Mem_R_EN;

  logic [3:0]  Exe_Dest;
  logic        Exe_WB_EN;
  logic        Exe_Mem_R_EN;
  logic [3:0]  Mem_Dest;
  logic        Mem_WB_EN;
  logic [3:0]  WB_Dest;
  logic        WB_WB_EN;
  logic [15:0] pending_mask;
  logic [1:0]  inflight_cnt;
  logic        flush_pending;

  // Core side: drives the ID instruction and stall controls, observes the slots.
  modport master (
    output freeze, flush, hazard, ID_Dest, ID_WB_EN, ID_Mem_R_EN,
    input  Exe_Dest, Exe_WB_EN, Exe_Mem_R_EN, Mem_Dest, Mem_WB_EN,
           WB_Dest, WB_WB_EN, pending_mask, inflight_cnt, flush_pending
  );

  // Scoreboard side.
  modport slave (
    input  freeze, flush, hazard, ID_Dest, ID_WB_EN, ID_Mem_R_EN,
    output Exe_Dest, Exe_WB_EN, Exe_Mem_R_EN, Mem_Dest, Mem_WB_EN,
           WB_Dest, WB_WB_EN, pending_mask, inflight_cnt, flush_pending
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Destination-register scoreboard for the EXE/MEM/WB stages: shifts metadata
// with the pipeline, honours freeze/flush/hazard and publishes a pending mask.
module pipeline_scoreboard (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_scoreboard_if.slave   bus
);

  typedef struct packed {
    logic [3:0] dest;
    logic       wb_en;
    logic       mem_r_en;
  } exe_slot_t;

  typedef struct packed {
    logic [3:0] dest;
    logic       wb_en;
  } slot_t;

  exe_slot_t exe_q;
  slot_t     mem_q;
  slot_t     wb_q;
  logic      flush_pending_q;

  logic      squash;
  exe_slot_t exe_in;

  // A flush seen while frozen is remembered and applied on the first live edge.
  assign squash = bus.flush | flush_pending_q | bus.hazard;
  assign exe_in = squash ? '0 : exe_slot_t'{dest:     bus.ID_Dest,
                                            wb_en:    bus.ID_WB_EN,
                                            mem_r_en: bus.ID_Mem_R_EN};

  // NOTE: state registers use non-blocking assignments so that WB <= MEM and
  // MEM <= EXE all sample the pre-edge values, giving a true shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q           <= '0;
      mem_q           <= '0;
      wb_q            <= '0;
      flush_pending_q <= 1'b0;
    end else if (bus.freeze) begin
      if (bus.flush) flush_pending_q <= 1'b1;
    end else begin
      wb_q            <= mem_q;
      mem_q           <= slot_t'{dest: exe_q.dest, wb_en: exe_q.wb_en};
      exe_q           <= exe_in;
      flush_pending_q <= 1'b0;
    end
  end

  logic [15:0] pending_mask;

  // NOTE: the mask is cleared before the per-slot ORs so that every path
  // assigns it and no latch is inferred.
  always_comb begin
    pending_mask = '0;
    if (exe_q.wb_en) pending_mask[exe_q.dest] = 1'b1;
    if (mem_q.wb_en) pending_mask[mem_q.dest] = 1'b1;
    if (wb_q.wb_en)  pending_mask[wb_q.dest]  = 1'b1;
  end

  assign bus.pending_mask  = pending_mask;
  assign bus.inflight_cnt  = 2'(exe_q.wb_en) + 2'(mem_q.wb_en) + 2'(wb_q.wb_en);
  assign bus.flush_pending = flush_pending_q;

  // Dest fields pass through regardless of WB_EN; consumers gate on WB_EN.
  assign bus.Exe_Dest     = exe_q.dest;
  assign bus.Exe_WB_EN    = exe_q.wb_en;
  assign bus.Exe_Mem_R_EN = exe_q.mem_r_en;
  assign bus.Mem_Dest     = mem_q.dest;
  assign bus.Mem_WB_EN    = mem_q.wb_en;
  assign bus.WB_Dest      = wb_q.dest;
  assign bus.WB_WB_EN     = wb_q.wb_en;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Scoreboard bench for pipeline_scoreboard: a queue-based pipeline model pushes
// expected outputs after each edge, and a negedge monitor pops and compares.
module tb_pipeline_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_scoreboard_if bus ();

  pipeline_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] dest;
    logic       wb;
    logic       ld;
  } ent_t;

  typedef struct packed {
    logic [3:0]  ed;
    logic        ew;
    logic        el;
    logic [3:0]  md;
    logic        mw;
    logic [3:0]  wd;
    logic        ww;
    logic [15:0] mask;
    logic [1:0]  cnt;
    logic        fp;
  } obs_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ent_t pipe[$];   // index 0 = EXE, 1 = MEM, 2 = WB
  logic model_fp;
  obs_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic obs_t predict();
    obs_t o;
    int   n;
    o      = '0;
    o.ed   = pipe[0].dest;
    o.ew   = pipe[0].wb;
    o.el   = pipe[0].ld;
    o.md   = pipe[1].dest;
    o.mw   = pipe[1].wb;
    o.wd   = pipe[2].dest;
    o.ww   = pipe[2].wb;
    n      = 0;
    foreach (pipe[i]) begin
      if (pipe[i].wb) begin
        o.mask[pipe[i].dest] = 1'b1;
        n++;
      end
    end
    o.cnt  = 2'(n);
    o.fp   = model_fp;
    return o;
  endfunction

  function automatic void model_edge(input logic r, fz, fl, hz,
                                     input logic [3:0] d, input logic w, ld);
    ent_t e;
    ent_t z;
    z = '{dest: 4'd0, wb: 1'b0, ld: 1'b0};
    if (r) begin
      pipe.delete();
      repeat (3) pipe.push_back(z);
      model_fp = 1'b0;
    end else if (fz) begin
      if (fl) model_fp = 1'b1;
    end else begin
      e = (fl || model_fp || hz) ? z : '{dest: d, wb: w, ld: ld};
      pipe.push_front(e);
      void'(pipe.pop_back());
      model_fp = 1'b0;
    end
  endfunction

  // One clock: drive inputs, let the edge happen, record what should follow.
  task automatic step(input logic r, fz, fl, hz,
                      input logic [3:0] d, input logic w, ld);
    rst             = r;
    bus.freeze      = fz;
    bus.flush       = fl;
    bus.hazard      = hz;
    bus.ID_Dest     = d;
    bus.ID_WB_EN    = w;
    bus.ID_Mem_R_EN = ld;
    @(posedge clk);
    model_edge(r, fz, fl, hz, d, w, ld);
    exp_q.push_back(predict());
    #1;
  endtask

  task automatic issue(input logic [3:0] d, input logic w);
    step(1'b0, 1'b0, 1'b0, 1'b0, d, w, 1'b0);
  endtask

  // Monitor: compares every cycle the model has produced an expectation for.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{ed: bus.Exe_Dest, ew: bus.Exe_WB_EN, el: bus.Exe_Mem_R_EN,
              md: bus.Mem_Dest, mw: bus.Mem_WB_EN,
              wd: bus.WB_Dest,  ww: bus.WB_WB_EN,
              mask: bus.pending_mask, cnt: bus.inflight_cnt,
              fp: bus.flush_pending};
        check($sformatf("cycle%0d_outputs", cyc), 64'(a), 64'(e));
        cyc++;
      end
    end
  end

  logic [15:0] plain_mask [5] = '{16'h0008, 16'h0028, 16'h0028, 16'h0020, 16'h0000};
  logic [1:0]  plain_cnt  [5] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};

  initial begin
    int waited;
    model_fp = 1'b0;
    repeat (3) pipe.push_back('{dest: 4'd0, wb: 1'b0, ld: 1'b0});

    // Reset with garbage on every input.
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
    check("reset_mask", 64'(bus.pending_mask), 64'h0);
    check("reset_cnt",  64'(bus.inflight_cnt), 64'h0);
    check("reset_slots", 64'({bus.Exe_Dest, bus.Exe_WB_EN, bus.Exe_Mem_R_EN, bus.Mem_Dest,
                              bus.Mem_WB_EN, bus.WB_Dest, bus.WB_WB_EN, bus.flush_pending}), 64'h0);

    // Plain flow: 3, 5, then bubbles.
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       issue(4'd3, 1'b1);
        1:       issue(4'd5, 1'b1);
        default: issue(4'd0, 1'b0);
      endcase
      check($sformatf("plain_mask%0d", i), 64'(bus.pending_mask), 64'(plain_mask[i]));
      check($sformatf("plain_cnt%0d", i),  64'(bus.inflight_cnt), 64'(plain_cnt[i]));
      if (i == 0) check("plain_exe3", 64'(bus.Exe_Dest), 64'd3);
      if (i == 1) check("plain_mem3_exe5", 64'({bus.Mem_Dest, bus.Exe_Dest}), 64'h35);
      if (i == 2) check("plain_wb3", 64'(bus.WB_Dest), 64'd3);
    end

    // Freeze with EXE=7, MEM=2, WB=9; ID garbage must be ignored.
    issue(4'd9, 1'b1);
    issue(4'd2, 1'b1);
    issue(4'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1, 1'b1);
      check($sformatf("freeze_hold%0d", i),
            64'({bus.Exe_Dest, bus.Mem_Dest, bus.WB_Dest}), 64'h729);
    end
    issue(4'd0, 1'b0);
    check("freeze_release", 64'({bus.Mem_Dest, bus.WB_Dest}), 64'h72);

    // Deferred flush during a 2-cycle freeze.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
    check("defer_pending_set", 64'(bus.flush_pending), 64'd1);
    issue(4'd4, 1'b1);
    check("defer_bubble", 64'(bus.Exe_WB_EN), 64'd0);
    check("defer_pending_clr", 64'(bus.flush_pending), 64'd0);

    // Hazard bubble while prior EXE contents advance.
    issue(4'd8, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1);
    check("hazard_exe", 64'({bus.Exe_WB_EN, bus.Exe_Mem_R_EN}), 64'h0);
    check("hazard_mem", 64'({bus.Mem_Dest, bus.Mem_WB_EN}), 64'h11);

    // Duplicate tags in all three slots.
    repeat (3) issue(4'd1, 1'b1);
    check("dup_mask", 64'(bus.pending_mask), 64'h0002);
    check("dup_cnt",  64'(bus.inflight_cnt), 64'd3);

    // Reset while frozen with a flush pending clears everything.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b1, 1'b1);
    check("rst_clears_pending", 64'({bus.flush_pending, bus.pending_mask}), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 10),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 30));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
